// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl
// Turns raw PS/2 scancode bytes into key events {ext, brk, code}. An E0/F0
// prefix state machine assembles each event, a small FIFO buffers the events,
// and a four-register window on the 68k bus lets the CPU read them.
// The interrupt line is asserted while events are pending and irq_en is set.

module ps2_key_event_ctrl #(
   parameter int FIFO_DEPTH     = 8,        // power of two, 2..16
   parameter int PREFIX_TIMEOUT = 125_000   // cycles a lone prefix may wait
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       dec_valid,
   input  logic [7:0] dec_data,
   output logic       dec_int_clear,
   input  logic       cs,
   input  logic       rd,
   input  logic       wr,
   input  logic [1:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata,
   output logic       irq
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(PREFIX_TIMEOUT + 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
   localparam logic [TW-1:0] TO_LAST  = TW'(PREFIX_TIMEOUT - 1);

   localparam logic [1:0] A_STATUS = 2'd0;
   localparam logic [1:0] A_FLAGS  = 2'd1;
   localparam logic [1:0] A_CODE   = 2'd2;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } key_evt_t;

   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} pfx_state_t;

   pfx_state_t      state;
   logic [TW-1:0]   tcnt;

   key_evt_t        mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count;
   key_evt_t        head;

   logic            irq_en, ovf, pfx_drop;

   logic            wr_ctl, rd_stb, flush, clr_ovf, clr_pfx;
   logic            is_e0, take_f0, evt_vld, timeout_hit;
   key_evt_t        evt;
   logic            not_empty, pop_ok, push_ok, ovf_set;
   logic [7:0]      status;
   logic            unused_wdata;

   // ---------------------------------------------------------------
   // Bus strobes. The upper write-data bits of the control register
   // carry nothing.
   // ---------------------------------------------------------------
   assign rd_stb       = cs & rd;
   assign wr_ctl       = cs & wr & (addr == A_STATUS);
   assign flush        = wr_ctl & wdata[1];
   assign clr_ovf      = wr_ctl & wdata[2];
   assign clr_pfx      = wr_ctl & wdata[3];
   assign unused_wdata = &{1'b0, wdata[7:4]};

   // Classify the incoming byte against the current prefix state
   always_comb begin
      is_e0    = (dec_data == 8'hE0);
      // F0 is only a prefix when no break prefix is already pending;
      // after one it is treated as an ordinary code.
      take_f0  = (dec_data == 8'hF0) && (state == IDLE || state == GOT_E0);
      evt_vld  = dec_valid && !is_e0 && !take_f0;
      evt.ext  = (state == GOT_E0) || (state == GOT_E0F0);
      evt.brk  = (state == GOT_F0) || (state == GOT_E0F0);
      evt.code = dec_data;
      // An arriving byte beats an expiring prefix in the same cycle.
      timeout_hit = !dec_valid && (state != IDLE) && (tcnt == TO_LAST);
   end

   // Prefix state machine with its stale-prefix timer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         tcnt  <= '0;
      end else if (flush) begin
         state <= IDLE;
         tcnt  <= '0;
      end else if (dec_valid) begin
         tcnt <= '0;
         if (is_e0)
            state <= GOT_E0;
         else if (take_f0)
            state <= (state == IDLE) ? GOT_F0 : GOT_E0F0;
         else
            state <= IDLE;
      end else if (timeout_hit) begin
         state <= IDLE;
         tcnt  <= '0;
      end else if (state != IDLE) begin
         tcnt <= tcnt + 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // Event FIFO. A pop frees a slot in the same cycle, so push+pop
   // while full is legal; a pop while empty does nothing.
   // ---------------------------------------------------------------
   assign not_empty = (count != '0);
   assign head      = mem[rd_ptr];
   assign pop_ok    = rd_stb && (addr == A_CODE) && not_empty && !flush;
   assign push_ok   = evt_vld && !flush && ((count != FULL_CNT) || pop_ok);
   assign ovf_set   = evt_vld && !flush && (count == FULL_CNT) && !pop_ok;

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FIFO storage, written only on an accepted push
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= evt;
   end

   // ---------------------------------------------------------------
   // Control / sticky status. A new error in the same cycle as its
   // clear leaves the bit set so the event is never lost.
   // ---------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en   <= 1'b0;
         ovf      <= 1'b0;
         pfx_drop <= 1'b0;
      end else begin
         if (wr_ctl) irq_en <= wdata[0];
         if (ovf_set)      ovf <= 1'b1;
         else if (clr_ovf) ovf <= 1'b0;
         if (timeout_hit && !flush) pfx_drop <= 1'b1;
         else if (clr_pfx)          pfx_drop <= 1'b0;
      end
   end

   assign status = {irq_en, ovf, pfx_drop, 5'(count)};

   // Registered read port; holds its value between reads
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rdata <= 8'h00;
      end else if (rd_stb) begin
         case (addr)
            A_STATUS: rdata <= status;
            A_FLAGS:  rdata <= not_empty ? {6'b0, head.ext, head.brk} : 8'h00;
            A_CODE:   rdata <= not_empty ? head.code : 8'h00;
            default:  rdata <= 8'h00;
         endcase
      end
   end

   // One-cycle acknowledge back to the decoder for every accepted byte
   always_ff @(posedge clk or posedge reset) begin
      if (reset) dec_int_clear <= 1'b0;
      else       dec_int_clear <= dec_valid;
   end

   assign irq = irq_en && not_empty;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
// Scoreboard bench for ps2_key_event_ctrl: bytes are modelled as they are
// driven, expected events are queued, and CPU reads are compared against them.

module tb_ps2_key_event_ctrl;

   localparam int DEPTH = 8;
   localparam int TO    = 40;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ev_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       dec_valid = 1'b0;
   logic [7:0] dec_data = 8'h00;
   logic       dec_int_clear;
   logic       cs = 1'b0, rd = 1'b0, wr = 1'b0;
   logic [1:0] addr = 2'd0;
   logic [7:0] wdata = 8'h00;
   logic [7:0] rdata;
   logic       irq;

   int errors = 0;
   int checks = 0;

   ev_t  q[$];
   logic m_ext = 0, m_brk = 0, m_irq_en = 0, m_ovf = 0, m_pfx = 0;

   ps2_key_event_ctrl #(.FIFO_DEPTH(DEPTH), .PREFIX_TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .dec_valid(dec_valid), .dec_data(dec_data), .dec_int_clear(dec_int_clear),
      .cs(cs), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
      .rdata(rdata), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // ---- reference model ----
   task automatic push_evt(input ev_t e);
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1'b1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) begin
         m_ext = 1'b1; m_brk = 1'b0;
      end else if (b == 8'hF0 && !m_brk) begin
         m_brk = 1'b1;
      end else begin
         push_evt({m_ext, m_brk, b});
         m_ext = 1'b0; m_brk = 1'b0;
      end
   endtask

   task automatic model_ctl(input logic [7:0] d);
      m_irq_en = d[0];
      if (d[1]) begin q.delete(); m_ext = 1'b0; m_brk = 1'b0; end
      if (d[2]) m_ovf = 1'b0;
      if (d[3]) m_pfx = 1'b0;
   endtask

   function automatic logic [7:0] exp_status();
      return {m_irq_en, m_ovf, m_pfx, 5'(q.size())};
   endfunction

   // ---- bus drivers ----
   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      dec_valid = 1'b1; dec_data = b;
      model_byte(b);
      @(negedge clk);
      dec_valid = 1'b0;
      chk("int_clear_hi", dec_int_clear, 1);
      @(negedge clk);
      chk("int_clear_lo", dec_int_clear, 0);
   endtask

   task automatic reg_rd(input logic [1:0] a, output logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; rd = 1'b1; addr = a;
      @(negedge clk);
      cs = 1'b0; rd = 1'b0;
      d = rdata;
   endtask

   task automatic ctl_wr(input logic [7:0] d);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = d;
      model_ctl(d);
      @(negedge clk);
      cs = 1'b0; wr = 1'b0;
   endtask

   task automatic check_status(input string tag);
      logic [7:0] d;
      reg_rd(2'd0, d);
      chk(tag, d, exp_status());
      chk({tag, "_irq"}, irq, m_irq_en && (q.size() != 0));
   endtask

   task automatic pop_check(input string tag);
      logic [7:0] f, c;
      ev_t e;
      reg_rd(2'd1, f);
      reg_rd(2'd2, c);
      e = '0;
      if (q.size() != 0) e = q.pop_front();
      chk({tag, "_flags"}, f, {6'b0, e.ext, e.brk});
      chk({tag, "_code"}, c, e.code);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [7:0] d;
      ev_t e;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_irq", irq, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_int_clear", dec_int_clear, 0);
      reset = 1'b0;
      check_status("rst_status");

      // four flavours of event
      send_byte(8'h1C);
      send_byte(8'hF0); send_byte(8'h1C);
      send_byte(8'hE0); send_byte(8'h75);
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
      check_status("four_status");
      for (int i = 0; i < 4; i++) pop_check("four");
      check_status("four_empty");

      // irq timing
      ctl_wr(8'h01);
      chk("irq_idle", irq, 0);
      @(negedge clk);
      dec_valid = 1'b1; dec_data = 8'h1C; model_byte(8'h1C);
      chk("irq_pre", irq, 0);
      @(negedge clk);
      dec_valid = 1'b0;
      chk("irq_rise", irq, 1);
      chk("irq_int_clear", dec_int_clear, 1);
      pop_check("irq");
      chk("irq_fall", irq, 0);
      check_status("irq_status");

      // overflow
      for (int i = 0; i < 9; i++) send_byte(8'(8'h10 + i));
      check_status("ovf_status");
      ctl_wr(8'h05);
      check_status("ovf_cleared");

      // clear of ovf coincident with a new overflow keeps it set
      @(negedge clk);
      dec_valid = 1'b1; dec_data = 8'h66;
      cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 8'h05;
      model_ctl(8'h05); model_byte(8'h66);
      @(negedge clk);
      dec_valid = 1'b0; cs = 1'b0; wr = 1'b0;
      check_status("ovf_clr_race");
      ctl_wr(8'h05);

      // push and pop on a full FIFO in the same cycle
      @(negedge clk);
      dec_valid = 1'b1; dec_data = 8'h55;
      cs = 1'b1; rd = 1'b1; addr = 2'd2;
      @(negedge clk);
      dec_valid = 1'b0; cs = 1'b0; rd = 1'b0;
      e = q.pop_front();
      chk("full_pp_code", rdata, e.code);
      model_byte(8'h55);
      check_status("full_pp_status");
      for (int i = 0; i < DEPTH; i++) pop_check("drain");

      // reads while empty
      reg_rd(2'd2, d); chk("empty_code", d, 0);
      reg_rd(2'd1, d); chk("empty_flags", d, 0);
      check_status("empty_status");

      // addr3 reads zero, writes ignored
      send_byte(8'h2A);
      @(negedge clk);
      cs = 1'b1; wr = 1'b1; addr = 2'd3; wdata = 8'hFF;
      @(negedge clk);
      cs = 1'b0; wr = 1'b0;
      reg_rd(2'd3, d); chk("addr3", d, 0);
      check_status("addr3_status");
      pop_check("addr3");

      // back-to-back bytes
      @(negedge clk);
      dec_valid = 1'b1; dec_data = 8'hE0; model_byte(8'hE0);
      @(negedge clk);
      dec_data = 8'h75; model_byte(8'h75);
      @(negedge clk);
      dec_data = 8'h1C; model_byte(8'h1C);
      @(negedge clk);
      dec_valid = 1'b0;
      check_status("b2b_status");
      pop_check("b2b");
      pop_check("b2b");

      // prefix just inside the timeout survives
      send_byte(8'hE0);
      repeat (TO - 5) @(negedge clk);
      send_byte(8'h75);
      check_status("to_short_status");
      pop_check("to_short");

      // prefix beyond the timeout is discarded
      send_byte(8'hE0);
      repeat (TO + 5) @(negedge clk);
      m_ext = 1'b0; m_brk = 1'b0; m_pfx = 1'b1;
      send_byte(8'h1C);
      check_status("to_long_status");
      pop_check("to_long");
      ctl_wr(8'h09);
      check_status("pfx_cleared");

      // flush coincident with a byte, FSM in GOT_E0F0
      send_byte(8'h1C); send_byte(8'h2D);
      send_byte(8'hE0); send_byte(8'hF0);
      @(negedge clk);
      dec_valid = 1'b1; dec_data = 8'h33;
      cs = 1'b1; wr = 1'b1; addr = 2'd0; wdata = 8'h03;
      model_ctl(8'h03);
      @(negedge clk);
      dec_valid = 1'b0; cs = 1'b0; wr = 1'b0;
      check_status("flush_status");
      send_byte(8'h1C);
      check_status("flush_next_status");
      pop_check("flush_next");

      // asynchronous reset mid-prefix
      send_byte(8'h1C);
      check_status("prerst_status");
      send_byte(8'hE0); send_byte(8'hF0);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      chk("arst_irq", irq, 0);
      chk("arst_rdata", rdata, 0);
      chk("arst_int_clear", dec_int_clear, 0);
      q.delete(); m_ext = 0; m_brk = 0; m_irq_en = 0; m_ovf = 0; m_pfx = 0;
      @(negedge clk);
      reset = 1'b0;
      check_status("arst_status");
      send_byte(8'h1C);
      check_status("arst_next_status");
      pop_check("arst_next");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ps2_key_event_ctrl.md
# ps2_key_event_ctrl

Sits between the PS/2 byte decoder and the 68k peripheral bus. It sequences raw scancode bytes through a prefix state machine (E0 extended, F0 break) into complete key events and buffers them in a FIFO. It exposes a small register file to the CPU and drives the CPU interrupt line. It also issues the decoder's interrupt-clear.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries; power of two, 2..16.
- `PREFIX_TIMEOUT`, default 125_000: clk cycles (5 ms at 25 MHz) a pending prefix survives without a following byte.
- `clk`  in  1  system clock, 25 MHz.
- `reset`  in  1  asynchronous, active-high.
- `dec_valid`  in  1  one-cycle pulse from the decoder; `dec_data` is good that cycle.
- `dec_data`  in  8  scancode byte from the decoder.
- `dec_int_clear`  out  1  one-cycle pulse to the decoder after each accepted byte.
- `cs`  in  1  register select.
- `rd`  in  1  read strobe, one cycle per access, qualified by `cs`.
- `wr`  in  1  write strobe, one cycle per access, qualified by `cs`.
- `addr`  in  2  register address.
- `wdata`  in  8  write data.
- `rdata`  out  8  read data, registered.
- `irq`  out  1  level interrupt to the CPU.

## Operation
- **Prefix FSM states:** `IDLE`, `GOT_E0`, `GOT_F0`, `GOT_E0F0`.
  - `IDLE`: E0 → `GOT_E0`; F0 → `GOT_F0`.
  - `GOT_E0`: F0 → `GOT_E0F0`; E0 → stay in `GOT_E0`.
  - `GOT_F0` / `GOT_E0F0`: E0 → `GOT_E0` (restart).
  - Any other byte in any state: push event {ext, brk, code} and return to `IDLE`. ext=1 in `GOT_E0`/`GOT_E0F0`; brk=1 in `GOT_F0`/`GOT_E0F0`.
  - Every other byte value, including E1, AA and FF, is an ordinary code.
- **Timeout counter:** cleared on each accepted byte; counts while the FSM is not in `IDLE`. On reaching `PREFIX_TIMEOUT`: FSM → `IDLE`, prefix discarded, sticky `pfx_drop` set.
- **FIFO:** 10-bit entries {ext, brk, code[7:0]}. `count` is width clog2(DEPTH)+1.
  - Push when full: event dropped, sticky `ovf` set.
  - Push and pop in the same cycle: both take effect, including when full (no `ovf`) and when empty (pop ignored).
- **Register map:**
  - addr0 read STATUS = {`irq_en`, `ovf`, `pfx_drop`, `count[4:0]`}.
  - addr0 write: bit0 `irq_en`; bit1 flush (self-clearing); bit2 clear `ovf`; bit3 clear `pfx_drop`.
  - addr1 read FLAGS = {6'b0, ext, brk} of the head entry; no pop.
  - addr2 read CODE = head code; pops the entry.
  - addr3: reads 0x00, writes ignored.
  - Reading CODE or FLAGS while empty returns 0x00 with no pop and no error.
- **Flush:** empties the FIFO and forces the FSM to `IDLE`. Flush wins over a same-cycle push.
- **Sticky clears:** a clear of `ovf` in the same cycle as a new overflow leaves `ovf` set.
- **`irq`** = `irq_en` && (`count` != 0); combinational from registers.

## Timing
- **Reset values:** `irq`=0, `rdata`=0x00, `dec_int_clear`=0, `irq_en`=0, `ovf`=0, `pfx_drop`=0, `count`=0, FSM `IDLE`, timeout counter 0.
- **Byte acceptance:** `dec_valid` sampled at edge N.
  - FSM state and FIFO push update at N.
  - `count` and `irq` reflect the push from cycle N+1.
  - `dec_int_clear` is high during cycle N+1 only.
- **Reads:** `rd` sampled at edge N; `rdata` is valid from N+1 and holds until the next read. A CODE pop decrements `count` visibly from N+1.
- **Writes:** take effect at the sampling edge; a flush shows `count`=0 from N+1.
- **Throughput:** back-to-back `dec_valid` on consecutive cycles must each be accepted. The decoder's real rate is about 1 per 1.1 ms.
- **Mid-operation reset:** asynchronous reset clears everything immediately, including a pending prefix.

## Test plan
- Bytes 1C, F0 1C, E0 75, E0 F0 75 → four events with (ext, brk, code) = (0,0,1C), (0,1,1C), (1,0,75), (1,1,75); STATUS `count`=4.
- `irq_en`=1 with empty FIFO, then byte 1C → `irq` rises one cycle after `dec_valid`. Reading CODE returns 0x1C, after which `irq` drops and `count`=0.
- 9 ordinary bytes with DEPTH=8 → `count`=8, `ovf`=1, first 8 codes read back in order; writing 0x04 clears `ovf`.
- E0, then silence for `PREFIX_TIMEOUT` cycles, then 1C → event (0,0,1C) and `pfx_drop`=1.
- FIFO full with a CODE read and `dec_valid` in the same cycle → `count` stays 8, `ovf`=0, new event lands at the tail.
- Flush write coincident with `dec_valid`; also reset asserted while in `GOT_E0F0` → `count`=0, FSM `IDLE`, and the next byte 1C is pushed as (0,0,1C).
